// File: rtl/io_value_port.sv
// rtl/io_value_port.sv - CPU bus bridge to the value-storage I/O device
// Output-side FIFO with sticky status, optional irq and read-ready ack generation.
module io_value_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] bus_addr,
  input  logic       bus_write_en,
  input  logic [7:0] bus_write_data,
  input  logic       bus_read_en,
  output logic [7:0] bus_read_data,
  output logic       bus_read_valid,
  input  logic [7:0] dev_output_value,
  input  logic       dev_output_trigger,
  output logic       dev_read_ready_trigger,
  output logic [7:0] dev_input_value,
  output logic       dev_input_trigger,
  output logic       irq
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    count;
  logic          trig_q;
  logic          ovf;
  logic          unf;
  logic          pending_ack;
  logic          ack_on_push;
  logic          irq_en;

  logic       empty;
  logic       full;
  logic       data_rd;
  logic       pop;
  logic       underflow;
  logic       flush;
  logic       push_edge;
  logic       push_ok;
  logic       drop;
  logic [3:0] count_next;
  logic       ack_next;
  logic       pend_set;
  logic       status_wr;
  logic [7:0] rd_mux;

  always_comb begin
    empty      = (count == 4'd0);
    full       = (count == DEPTH_C);
    data_rd    = bus_read_en && (bus_addr == ADDR_DATA);
    pop        = data_rd && !empty;
    underflow  = data_rd && empty;
    flush      = bus_write_en && (bus_addr == ADDR_CONTROL) && bus_write_data[7];
    status_wr  = bus_write_en && (bus_addr == ADDR_STATUS);
    push_edge  = dev_output_trigger && !trig_q;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok    = push_edge && !flush && (!full || pop);
    drop       = push_edge && !flush && full && !pop;
    count_next = flush ? 4'd0 : (count + {3'b000, push_ok} - {3'b000, pop});
    pend_set   = ack_on_push && push_ok && (count_next == DEPTH_C);
    ack_next   = (!ack_on_push && pop)
               | (ack_on_push && push_ok && (count_next < DEPTH_C))
               | (pending_ack && (pop || flush));
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus_addr)
      ADDR_DATA:    rd_mux = empty ? 8'h00 : mem[rd_ptr];
      ADDR_STATUS:  rd_mux = {ovf, unf, pending_ack, full, count};
      ADDR_CONTROL: rd_mux = {6'b0, irq_en, ack_on_push};
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dev_output_value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= 4'd0;
      trig_q                 <= 1'b0;
      ovf                    <= 1'b0;
      unf                    <= 1'b0;
      pending_ack            <= 1'b0;
      ack_on_push            <= 1'b0;
      irq_en                 <= 1'b0;
      bus_read_data          <= 8'h00;
      bus_read_valid         <= 1'b0;
      dev_read_ready_trigger <= 1'b0;
      dev_input_value        <= 8'h00;
      dev_input_trigger      <= 1'b0;
    end else begin
      trig_q                 <= dev_output_trigger;
      count                  <= count_next;
      bus_read_valid         <= bus_read_en;
      dev_read_ready_trigger <= ack_next;
      dev_input_trigger      <= bus_write_en && (bus_addr == ADDR_DATA);

      if (bus_read_en) bus_read_data <= rd_mux;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end

      // Setting a sticky wins over a same-cycle write-1-to-clear.
      if (drop)                              ovf <= 1'b1;
      else if (status_wr && bus_write_data[7]) ovf <= 1'b0;
      if (underflow)                         unf <= 1'b1;
      else if (status_wr && bus_write_data[6]) unf <= 1'b0;

      if (pend_set)          pending_ack <= 1'b1;
      else if (pop || flush) pending_ack <= 1'b0;

      if (bus_write_en && (bus_addr == ADDR_DATA)) dev_input_value <= bus_write_data;
      if (bus_write_en && (bus_addr == ADDR_CONTROL)) begin
        ack_on_push <= bus_write_data[0];
        irq_en      <= bus_write_data[1];
      end
    end
  end

  assign irq = irq_en && ((count != 4'd0) || ovf);

endmodule

// File: tb/tb_io_value_port.sv
// tb/tb_io_value_port.sv - self-checking bench for io_value_port
// Register vectors from a table; read data checked through an expected-value queue.
module tb_io_value_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bus_addr;
  logic       bus_write_en;
  logic [7:0] bus_write_data;
  logic       bus_read_en;
  logic [7:0] bus_read_data;
  logic       bus_read_valid;
  logic [7:0] dev_output_value;
  logic       dev_output_trigger;
  logic       dev_read_ready_trigger;
  logic [7:0] dev_input_value;
  logic       dev_input_trigger;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  io_value_port #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_write_en(bus_write_en), .bus_write_data(bus_write_data),
    .bus_read_en(bus_read_en), .bus_read_data(bus_read_data), .bus_read_valid(bus_read_valid),
    .dev_output_value(dev_output_value), .dev_output_trigger(dev_output_trigger),
    .dev_read_ready_trigger(dev_read_ready_trigger),
    .dev_input_value(dev_input_value), .dev_input_trigger(dev_input_trigger),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_read_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got valid with data 0x%0h, expected no read", bus_read_data);
      end else begin
        chk("rd_data", {24'b0, bus_read_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, output logic ack);
    bus_addr    = a;
    bus_read_en = 1'b1;
    exp_q.push_back(exp);
    tick();
    chk("rd_valid", {31'b0, bus_read_valid}, 32'd1);
    ack = dev_read_ready_trigger;
    bus_read_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_addr       = a;
    bus_write_data = d;
    bus_write_en   = 1'b1;
    tick();
    bus_write_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] v, output logic ack);
    dev_output_value   = v;
    dev_output_trigger = 1'b1;
    tick();
    ack = dev_read_ready_trigger;
    dev_output_trigger = 1'b0;
    tick();
  endtask

  vec_t vecs[13];
  logic ack;

  initial begin
    vecs[0]  = '{1'b0, 2'd1, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 2'd1, 8'h00, 8'h40};
    vecs[4]  = '{1'b1, 2'd1, 8'h40, 8'h00};
    vecs[5]  = '{1'b0, 2'd1, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 2'd2, 8'h03, 8'h00};
    vecs[7]  = '{1'b0, 2'd2, 8'h00, 8'h03};
    vecs[8]  = '{1'b1, 2'd2, 8'hFC, 8'h00};
    vecs[9]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 2'd3, 8'hFF, 8'h00};
    vecs[11] = '{1'b0, 2'd3, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 2'd1, 8'h00, 8'h00};

    reset = 1'b1;
    bus_addr = 2'd0; bus_write_en = 1'b0; bus_write_data = 8'h00; bus_read_en = 1'b0;
    dev_output_value = 8'h00; dev_output_trigger = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset asserted mid-push with a DATA write in flight
    wr(2'd2, 8'h02);
    dev_output_value = 8'h55; dev_output_trigger = 1'b1;
    bus_addr = 2'd0; bus_write_data = 8'h99; bus_write_en = 1'b1;
    tick();
    chk("pre_reset_irq", {31'b0, irq}, 32'd1);
    chk("pre_reset_din", {23'b0, dev_input_trigger, dev_input_value}, {23'b0, 1'b1, 8'h99});
    #2 reset = 1'b1;
    #1;
    chk("reset_outputs", {12'b0, bus_read_data, bus_read_valid, dev_read_ready_trigger,
                          dev_input_value, dev_input_trigger, irq}, 32'd0);
    dev_output_trigger = 1'b0; bus_write_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      else            rd(vecs[i].addr, vecs[i].exp, ack);
    end

    // Pop-driven mode
    push(8'h05, ack);
    chk("m0_push_no_ack", {31'b0, ack}, 32'd0);
    rd(2'd1, 8'h01, ack);
    rd(2'd0, 8'h05, ack);
    chk("m0_pop_ack", {31'b0, ack}, 32'd1);
    tick();
    chk("m0_ack_one_cycle", {31'b0, dev_read_ready_trigger}, 32'd0);
    rd(2'd1, 8'h00, ack);

    // Buffered mode: fill, overflow, pop services the pending ack
    wr(2'd2, 8'h01);
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), ack);
      chk($sformatf("m1_push%0d_ack", i + 1), {31'b0, ack}, (i < 3) ? 32'd1 : 32'd0);
      if (i == 3) rd(2'd1, 8'h34, ack);
    end
    rd(2'd1, 8'hB4, ack);
    rd(2'd0, 8'h10, ack);
    chk("m1_pending_ack", {31'b0, ack}, 32'd1);
    rd(2'd1, 8'h83, ack);
    wr(2'd1, 8'h80);

    // Full FIFO with a pop and push in the same cycle
    push(8'h20, ack);
    chk("full_push_pending", {31'b0, ack}, 32'd0);
    dev_output_value = 8'h21; dev_output_trigger = 1'b1;
    rd(2'd0, 8'h11, ack);
    chk("simul_ack", {31'b0, ack}, 32'd1);
    dev_output_trigger = 1'b0;
    tick();
    rd(2'd1, 8'h34, ack);
    rd(2'd0, 8'h12, ack);
    chk("drain_pending_ack", {31'b0, ack}, 32'd1);
    rd(2'd0, 8'h13, ack);
    chk("drain_no_ack", {31'b0, ack}, 32'd0);
    rd(2'd0, 8'h20, ack);
    rd(2'd0, 8'h21, ack);
    rd(2'd1, 8'h00, ack);

    // Flush turns a pending ack into an immediate ack
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), ack);
    wr(2'd2, 8'h81);
    chk("flush_ack", {31'b0, dev_read_ready_trigger}, 32'd1);
    rd(2'd1, 8'h00, ack);

    // Write path, held trigger, irq and flush
    wr(2'd2, 8'h00);
    wr(2'd0, 8'hA7);
    chk("din_pulse", {23'b0, dev_input_trigger, dev_input_value}, {23'b0, 1'b1, 8'hA7});
    tick();
    chk("din_hold", {23'b0, dev_input_trigger, dev_input_value}, {23'b0, 1'b0, 8'hA7});
    dev_output_value = 8'h3C; dev_output_trigger = 1'b1;
    repeat (5) tick();
    dev_output_trigger = 1'b0;
    tick();
    rd(2'd1, 8'h01, ack);
    chk("irq_disabled", {31'b0, irq}, 32'd0);
    wr(2'd2, 8'h02);
    chk("irq_count", {31'b0, irq}, 32'd1);
    wr(2'd2, 8'h82);
    chk("irq_after_flush", {31'b0, irq}, 32'd0);
    rd(2'd1, 8'h00, ack);
    rd(2'd2, 8'h02, ack);

    tick();
    tick();
    chk("rd_queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_value_port.md
Name: io_value_port

Overview:
- Memory-mapped bridge between the CPU data bus and the value-storage I/O device.
- CPU writes to DATA are forwarded to the device as a one-cycle input pulse plus value.
- Values the device emits on its output trigger are captured into a DEPTH-entry FIFO. The CPU pops them through DATA and monitors them through STATUS, an optional interrupt, or both.
- The block generates the device's read-ready handshake, in either pop-driven or buffered mode.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
- bus_write_en  in  1  write strobe, one cycle.
- bus_write_data  in  8  write data.
- bus_read_en  in  1  read strobe, one cycle.
- bus_read_data  out  8  registered read data.
- bus_read_valid  out  1  high one cycle after bus_read_en.
- dev_output_value  in  8  value from the device.
- dev_output_trigger  in  1  device output strobe.
- dev_read_ready_trigger  out  1  one-cycle acknowledge to the device.
- dev_input_value  out  8  value sent to the device.
- dev_input_trigger  out  1  one-cycle strobe to the device.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, any cycle, including mid-handshake):
  - FIFO empty; count 0.
  - Sticky flags and pending_ack cleared; CONTROL = 0.
  - All outputs 0.
- Capture:
  - dev_output_trigger is registered. A push occurs on a rising edge, i.e. the current sample is 1 and the previous registered sample is 0.
  - A trigger held high for N cycles pushes once.
  - dev_output_value is written in the same cycle the edge is detected.
- Overflow:
  - A push while full, with no pop in the same cycle, drops the value.
  - It sets OVF (sticky); count is unchanged.
- DATA read:
  - Not empty: bus_read_data = head value on the next cycle, and the head is popped.
  - Empty: returns 0x00, sets UNF (sticky), no pop.
- Pop and push in the same cycle:
  - Both take effect.
  - When full, the pop frees the slot first: push accepted, count unchanged, no OVF.
  - When empty, the read underflows (returns 0x00, UNF set) and the push is still accepted (count becomes 1).
- DATA write: next cycle, dev_input_value = bus_write_data and dev_input_trigger = 1 for exactly one cycle. dev_input_value holds until the next write.
- STATUS read: [7] OVF, [6] UNF, [5] pending_ack, [4] full, [3:0] count.
- STATUS write: write-1-to-clear on bits 7 and 6; other bits ignored.
- CONTROL register:
  - [0] ack_on_push, [1] irq_en.
  - Bits 1:0 are read/write.
  - Writing bit 7 = 1 flushes the FIFO: count 0, stickies untouched, bit not stored.
  - Reads return {6'b0, irq_en, ack_on_push}.
- Reserved address: reads return 0x00; writes are ignored.
- Read timing: bus_read_valid pulses one cycle after every bus_read_en, for any address. A read and a write in the same cycle are both serviced; the read returns pre-write contents.
- Ack generation when ack_on_push = 0: dev_read_ready_trigger pulses one cycle after each successful DATA pop.
- Ack generation when ack_on_push = 1:
  - After a push, the ack pulses on the next cycle if count < DEPTH after the push.
  - Otherwise pending_ack is set. The ack fires on the cycle after the next pop, and pending_ack then clears.
- Ack rules common to both modes:
  - At most one ack pulse per cycle.
  - A dropped (overflow) value never produces an ack.
  - Flush converts a pending_ack into an immediate ack on the next cycle.
- Mode change: changing ack_on_push leaves pending_ack intact. It is serviced on the next pop.
- Interrupt: irq = irq_en & ((count != 0) | OVF), combinational from registered state.
- Arithmetic: FIFO pointers wrap modulo DEPTH; count is 4 bits and saturates logically at DEPTH.

Test Plan:
1. Reset mid-push: assert reset while dev_output_trigger = 1 -> all outputs 0, STATUS reads 0x00.
2. Pop-driven mode:
   - Stimulus: device emits 0x05; later the CPU reads DATA.
   - Required: STATUS = 0x01; the read returns 0x05 with bus_read_valid one cycle later; dev_read_ready_trigger pulses exactly one cycle after the pop; STATUS then reads 0x00.
3. Buffered mode, DEPTH = 4:
   - Stimulus: ack_on_push = 1, five pushes 0x10..0x14, then one pop.
   - Required: acks follow pushes 1–3; push 4 fills the FIFO (STATUS = 0x34) and sets pending_ack; push 5 drops 0x14 and sets OVF (STATUS = 0xB4).
   - On the pop: returns 0x10, ack follows, pending_ack clears.
4. Full plus simultaneous push/pop: FIFO full, DATA read in the same cycle as a trigger edge -> read returns the head, new value stored at tail, count stays 4, OVF stays 0.
5. Underflow and W1C: read DATA on empty -> 0x00, UNF = 1; write STATUS 0x40 -> UNF = 0.
6. Write path, held trigger, irq:
   - Write DATA 0xA7: dev_input_trigger = 1 for one cycle with value 0xA7.
   - Hold dev_output_trigger high 5 cycles: count increments by 1 only.
   - irq_en = 1 with count = 1: irq = 1.
   - Flush via CONTROL 0x80: count = 0, irq = 0.
